// File: rtl/debug_cmd_sysclk_bridge_if.sv
// Command/strobe bundle between the JTAG-side debug logic and the system-clock bridge.
// Strobes, instruction and snapshot come in; the captured command and status flags go out.
interface debug_cmd_sysclk_bridge_if #(
    parameter int SR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    localparam int NUM_CMD = 2 ** IR_WIDTH;

    logic                vs_udr;
    logic                vs_uir;
    logic [IR_WIDTH-1:0] ir_in;
    logic [SR_WIDTH-1:0] sr;
    logic                cmd_ready;
    logic                overrun_clr;
    logic [SR_WIDTH-1:0] jdo;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic                cmd_valid;
    logic [NUM_CMD-1:0]  take_action;
    logic [NUM_CMD-1:0]  take_no_action;
    logic                ir_update;
    logic                overrun;

    modport master (
        output vs_udr, vs_uir, ir_in, sr, cmd_ready, overrun_clr,
        input  jdo, cmd_ir, cmd_valid, take_action, take_no_action, ir_update, overrun
    );

    modport slave (
        input  vs_udr, vs_uir, ir_in, sr, cmd_ready, overrun_clr,
        output jdo, cmd_ir, cmd_valid, take_action, take_no_action, ir_update, overrun
    );
endinterface

// File: rtl/debug_cmd_sysclk_bridge.sv
// Moves JTAG update-DR/update-IR strobes into clk, captures the debug command
// and holds it until the consumer accepts it; a command arriving while one is pending is dropped.
//
// state | meaning
// IDLE  | no command pending, cmd_valid = 0
// PEND  | captured command waiting for cmd_ready, cmd_valid = 1
module debug_cmd_sysclk_bridge #(
    parameter int SR_WIDTH    = 38,
    parameter int IR_WIDTH    = 2,
    parameter int SYNC_STAGES = 3
) (
    input logic                      clk,
    input logic                      reset,
    debug_cmd_sysclk_bridge_if.slave bus
);
    localparam int NUM_CMD = 2 ** IR_WIDTH;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    logic [SYNC_STAGES-1:0] udr_sync;
    logic [SYNC_STAGES-1:0] uir_sync;
    logic                   udr_hist;
    logic                   uir_hist;
    logic                   udr_evt;
    logic                   uir_evt;
    logic                   capture;
    logic                   drop;
    logic [0:0]             state;
    logic [0:0]             state_nxt;
    logic [SR_WIDTH-1:0]    jdo_q;
    logic [IR_WIDTH-1:0]    cmd_ir_q;
    logic [NUM_CMD-1:0]     ir_onehot;
    logic [NUM_CMD-1:0]     take_act_q;
    logic [NUM_CMD-1:0]     take_noact_q;
    logic                   ir_update_q;
    logic                   overrun_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            udr_sync <= '0;
            uir_sync <= '0;
            udr_hist <= 1'b0;
            uir_hist <= 1'b0;
        end else begin
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], bus.vs_udr};
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], bus.vs_uir};
            udr_hist <= udr_sync[SYNC_STAGES-1];
            uir_hist <= uir_sync[SYNC_STAGES-1];
        end
    end

    assign udr_evt = udr_sync[SYNC_STAGES-1] & ~udr_hist;
    assign uir_evt = uir_sync[SYNC_STAGES-1] & ~uir_hist;

    // A pending command accepted in the same cycle frees the slot for the new one.
    assign capture   = udr_evt & ((state == IDLE) | bus.cmd_ready);
    assign drop      = udr_evt & (state == PEND) & ~bus.cmd_ready;
    assign ir_onehot = NUM_CMD'(1) << bus.ir_in;

    always_comb begin
        state_nxt = state;
        if (capture)
            state_nxt = PEND;
        else if ((state == PEND) && bus.cmd_ready)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            jdo_q        <= '0;
            cmd_ir_q     <= '0;
            take_act_q   <= '0;
            take_noact_q <= '0;
            ir_update_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state        <= state_nxt;
            take_act_q   <= '0;
            take_noact_q <= '0;
            ir_update_q  <= uir_evt;
            if (capture) begin
                jdo_q    <= bus.sr;
                cmd_ir_q <= bus.ir_in;
                if (bus.sr[SR_WIDTH-1])
                    take_act_q   <= ir_onehot;
                else
                    take_noact_q <= ir_onehot;
            end
            if (drop)
                overrun_q <= 1'b1;
            else if (bus.overrun_clr)
                overrun_q <= 1'b0;
        end
    end

    assign bus.jdo            = jdo_q;
    assign bus.cmd_ir         = cmd_ir_q;
    assign bus.cmd_valid      = (state == PEND);
    assign bus.take_action    = take_act_q;
    assign bus.take_no_action = take_noact_q;
    assign bus.ir_update      = ir_update_q;
    assign bus.overrun        = overrun_q;
endmodule

// File: doc/debug_cmd_sysclk_bridge.md
DEBUG_CMD_SYSCLK_BRIDGE -- requirements
Module: debug_cmd_sysclk_bridge

Interface
REQ-001 Parameter SR_WIDTH, default 38: width of the debug shift-register snapshot and of jdo.
REQ-002 Parameter IR_WIDTH, default 2: width of the instruction register; NUM_CMD = 2**IR_WIDTH.
REQ-003 Parameter SYNC_STAGES, default 3: number of synchroniser flops per strobe; legal range 2..4.
REQ-004 Clocking and reset SHALL be as decided: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 vs_udr  in  1  update-DR level strobe from the JTAG clock domain; asynchronous to clk.
REQ-008 vs_uir  in  1  update-IR level strobe from the JTAG clock domain; asynchronous to clk.
REQ-009 ir_in  in  IR_WIDTH  current instruction; quasi-static while a strobe is high.
REQ-010 sr  in  SR_WIDTH  shift-register contents; quasi-static while vs_udr is high.
REQ-011 cmd_ready  in  1  consumer accepts the pending command.
REQ-012 overrun_clr  in  1  clears the sticky overrun flag.
REQ-013 jdo  out  SR_WIDTH  captured command data.
REQ-014 cmd_ir  out  IR_WIDTH  instruction captured with jdo.
REQ-015 cmd_valid  out  1  a captured command is pending.
REQ-016 take_action  out  NUM_CMD  one-hot, one-cycle pulse: action command on that IR.
REQ-017 take_no_action  out  NUM_CMD  one-hot, one-cycle pulse: no-action command on that IR.
REQ-018 ir_update  out  1  one-cycle pulse on each update-IR event.
REQ-019 overrun  out  1  sticky flag: a command was dropped.

Function
REQ-020 vs_udr and vs_uir SHALL each pass through a SYNC_STAGES flop chain, followed by one history flop.
REQ-021 An event SHALL be the last sync stage at 1 while the history flop is at 0 (rising edge).
REQ-022 Let N be the first clk edge that samples the strobe high; the udr event SHALL be acted on at edge N+SYNC_STAGES.
REQ-023 Each strobe assertion SHALL produce exactly one event, regardless of high time (>= 1 clk period).
REQ-024 FSM states SHALL be IDLE (cmd_valid=0) and PEND (cmd_valid=1).
REQ-025 IDLE + udr event: capture sr->jdo and ir_in->cmd_ir, go to PEND.
REQ-026 On a capture, if sr[SR_WIDTH-1]=1, take_action[ir_in] SHALL pulse; otherwise take_no_action[ir_in] SHALL pulse. The pulse is in the same cycle that cmd_valid first shows the new command.
REQ-027 PEND + cmd_ready + no event: go to IDLE; jdo and cmd_ir hold their values.
REQ-028 PEND + cmd_ready + udr event in the same cycle: accept the old command and capture the new one. Stay in PEND, cmd_valid stays 1, and the REQ-026 pulse fires.
REQ-029 PEND + no cmd_ready + udr event: drop the new command and set overrun. jdo, cmd_ir and cmd_valid are unchanged, and no take pulse fires.
REQ-030 jdo and cmd_ir SHALL change only on a capture.
REQ-031 A uir event SHALL pulse ir_update for one cycle, with no effect on jdo, the FSM or overrun. It is processed independently of a simultaneous udr event.
REQ-032 overrun SHALL clear on overrun_clr; if set and clear happen in the same cycle, set wins.
REQ-033 At most one bit of take_action|take_no_action SHALL be high in any cycle.

Reset
REQ-034 While reset is high, all outputs, sync chains, history flops and FSM state (IDLE) SHALL be 0, asynchronously.
REQ-035 Reset mid-operation SHALL discard any pending command and any partially synchronised event, and SHALL clear overrun.
REQ-036 A strobe that is held high across reset release SHALL yield exactly one event after SYNC_STAGES edges.

Verification
REQ-037 Default parameters, sr=38'h20_0000_0ABC (MSB=1), ir_in=2'b01, vs_udr high for 10 cycles -> at edge N+3: cmd_valid=1, jdo=38'h20_0000_0ABC, take_action=4'b0010 for one cycle; then cmd_ready=1 for one cycle -> cmd_valid=0.
REQ-038 Two udr strobes with cmd_ready=0; the second has sr=38'h0_0000_0001 -> overrun=1, jdo keeps the first value, no second pulse; overrun_clr and a third dropped event in the same cycle -> overrun stays 1.
REQ-039 A udr event coincides with cmd_ready=1 while in PEND; sr MSB=0, ir_in=2'b11 -> cmd_valid stays 1, jdo updates, take_no_action=4'b1000 for one cycle.
REQ-040 vs_uir and vs_udr rise together -> ir_update and the take pulse fire in the same cycle.
REQ-041 Reset asserted one cycle before the capture edge -> no capture and all outputs 0. Reset asserted while vs_udr is held high, then released -> exactly one capture, 3 edges after release.
REQ-042 Rerun REQ-037 with SR_WIDTH=64, IR_WIDTH=3, SYNC_STAGES=2 -> capture at edge N+2, one-hot pulse on bit ir_in of the 8-bit take vector.
